// File: rtl/wb_select_buffer_pkg.sv
// Shared select encodings and constants for the writeback select buffer.
// Select codes above SEL_LAST are illegal and are flagged by the top module.
package wb_pkg;

    localparam int SEL_ALU   = 0;
    localparam int SEL_MDR   = 1;
    localparam int SEL_HI    = 2;
    localparam int SEL_LO    = 3;
    localparam int SEL_EXC   = 4;
    localparam int SEL_ZERO  = 5;
    localparam int SEL_ONE   = 6;
    localparam int SEL_SHIFT = 7;
    localparam int SEL_LUI   = 8;
    localparam int SEL_LAST  = 8;

    localparam int EXC_CONST_DEFAULT = 227;
    localparam int IMM_W             = 16;
    localparam int ERR_CNT_W         = 8;

    function automatic logic sel_is_legal(input int unsigned sel_val);
        return sel_val <= SEL_LAST;
    endfunction

endpackage

// File: rtl/wb_select_buffer_fifo.sv
// Generic circular FIFO with occupancy output.
// Latency: a push is visible on out_* the cycle after it is accepted.
// Backpressure: in_rdy drops only when full; it never looks at out_rdy.
module wb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [W-1:0]              in_dat,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [W-1:0]              out_dat,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push;
    logic             pop;

    assign in_rdy  = (level_q != LVL_W'(DEPTH));
    assign out_vld = (level_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign level   = level_q;

    assign push = in_vld && in_rdy;
    assign pop  = out_vld && out_rdy;

    // Pointers rely on DEPTH being a power of two to wrap for free.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/wb_select_buffer.sv
// Writeback source selector feeding a small FIFO toward the register-file write port.
// Latency: one cycle from accept to wb_* when the buffer is empty.
// Backpressure: in_ready = buffer not full; independent of wb_ready.
module wb_select_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int SEL_W     = 4,
    parameter int EXC_CONST = EXC_CONST_DEFAULT,
    parameter int DEPTH     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic [DATA_W-1:0]       mdr_out,
    input  logic [DATA_W-1:0]       hi,
    input  logic [DATA_W-1:0]       lo,
    input  logic [DATA_W-1:0]       shift_out,
    input  logic [IMM_W-1:0]        imm16,
    input  logic [SEL_W-1:0]        sel,
    input  logic [REG_AW-1:0]       dst,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [DATA_W-1:0]       wb_data,
    output logic [REG_AW-1:0]       wb_addr,
    output logic                    wb_we,
    output logic                    err_sel,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int ENT_W = DATA_W + REG_AW + 1;

    logic                 accept;
    logic                 sel_legal;
    logic                 ent_we;
    logic [DATA_W-1:0]    lui_val;
    logic [DATA_W-1:0]    sel_data;
    logic [ENT_W-1:0]     push_dat;
    logic [ENT_W-1:0]     head_dat;
    logic                 err_sel_q, err_sel_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        lui_val                  = '0;
        lui_val[DATA_W-1 -: IMM_W] = imm16;
    end

    always_comb begin
        sel_data = '0;
        case (int'(sel))
            SEL_ALU:   sel_data = alu_out;
            SEL_MDR:   sel_data = mdr_out;
            SEL_HI:    sel_data = hi;
            SEL_LO:    sel_data = lo;
            SEL_EXC:   sel_data = DATA_W'(EXC_CONST);
            SEL_ZERO:  sel_data = '0;
            SEL_ONE:   sel_data = DATA_W'(1);
            SEL_SHIFT: sel_data = shift_out;
            SEL_LUI:   sel_data = lui_val;
            default:   sel_data = '0;
        endcase
    end

    assign sel_legal = sel_is_legal(32'(sel));
    // r0 is hardwired zero, so writes to it are carried but never enabled.
    assign ent_we    = sel_legal && (dst != '0);
    assign push_dat  = {ent_we, dst, sel_legal ? sel_data : {DATA_W{1'b0}}};
    assign accept    = in_valid && in_ready;

    always_comb begin
        err_sel_d = err_sel_q;
        err_cnt_d = err_cnt_q;
        if (accept && !sel_legal) begin
            err_sel_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sel_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_sel_q <= err_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_sel = err_sel_q;
    assign err_cnt = err_cnt_q;

    wb_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (push_dat),
        .out_vld (wb_valid),
        .out_rdy (wb_ready),
        .out_dat (head_dat),
        .level   (level)
    );

    assign {wb_we, wb_addr, wb_data} = head_dat;

endmodule

// File: tb/tb_wb_select_buffer.sv
// Scoreboarded bench for wb_select_buffer: stimulus feeds an expectation queue,
// a negedge monitor pops and compares each entry the DUT hands out.
module tb_wb_select_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] alu_out, mdr_out, hi, lo, shift_out;
    logic [15:0] imm16;
    logic [3:0]  sel;
    logic [4:0]  dst;
    logic        in_valid, in_ready;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic        err_sel;
    logic [7:0]  err_cnt;
    logic [1:0]  level;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        we;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic m_err_sel = 1'b0;
    int   m_err_cnt = 0;
    logic tog_en;

    wb_select_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .alu_out   (alu_out),
        .mdr_out   (mdr_out),
        .hi        (hi),
        .lo        (lo),
        .shift_out (shift_out),
        .imm16     (imm16),
        .sel       (sel),
        .dst       (dst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .wb_we     (wb_we),
        .err_sel   (err_sel),
        .err_cnt   (err_cnt),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the writeback value as the select map defines it.
    function automatic exp_t model(input int unsigned s, input logic [4:0] d);
        exp_t r;
        r.a = d;
        case (s)
            0:       r.d = alu_out;
            1:       r.d = mdr_out;
            2:       r.d = hi;
            3:       r.d = lo;
            4:       r.d = 32'd227;
            5:       r.d = 32'd0;
            6:       r.d = 32'd1;
            7:       r.d = shift_out;
            8:       r.d = {imm16, 16'h0000};
            default: r.d = 32'd0;
        endcase
        r.we = (s <= 8) && (d != 5'd0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("level", 64'(level), 64'(q.size()));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
            chk("err_sel", 64'(err_sel), 64'(m_err_sel));
            chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
            if (wb_valid && wb_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected got=%0h expected=none", wb_data);
                end else begin
                    e = q.pop_front();
                    chk("wb_data", 64'(wb_data), 64'(e.d));
                    chk("wb_addr", 64'(wb_addr), 64'(e.a));
                    chk("wb_we", 64'(wb_we), 64'(e.we));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(32'(sel), dst));
                if (sel > 4'd8) begin
                    m_err_sel = 1'b1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
            end
        end
    end

    task automatic clear_model();
        q.delete();
        m_err_sel = 1'b0;
        m_err_cnt = 0;
    endtask

    task automatic rand_data();
        alu_out   = $urandom;
        mdr_out   = $urandom;
        hi        = $urandom;
        lo        = $urandom;
        shift_out = $urandom;
        imm16     = 16'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [3:0] s, input logic [4:0] d);
        bit ok = 1'b0;
        sel      = s;
        dst      = d;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=in_ready_low expected=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d expected=0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        #6;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sweep_exp [9];
        sweep_exp = '{32'hAAAA0001, 32'h12345678, 32'hDEAD0000, 32'h0000BEEF,
                      32'h000000E3, 32'h00000000, 32'h00000001, 32'hF0F0F0F0,
                      32'h12340000};
        in_valid = 1'b0; wb_ready = 1'b0; sel = '0; dst = '0; tog_en = 1'b0;
        alu_out = '0; mdr_out = '0; hi = '0; lo = '0; shift_out = '0; imm16 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_err_sel", 64'(err_sel), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Map sweep, one accept per cycle.
        alu_out = 32'hAAAA0001; mdr_out = 32'h12345678; hi = 32'hDEAD0000;
        lo = 32'h0000BEEF; shift_out = 32'hF0F0F0F0; imm16 = 16'h1234;
        wb_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sel = 4'(i); dst = 5'd3; in_valid = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                chk("sweep_data", 64'(wb_data), 64'(sweep_exp[i-1]));
                chk("sweep_we", 64'(wb_we), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sweep_data", 64'(wb_data), 64'(sweep_exp[8]));
        drain();

        // Backpressure: fill, try a third, then drain.
        wb_ready = 1'b0;
        rand_data();
        send(4'd0, 5'd1);
        send(4'd1, 5'd2);
        @(negedge clk);
        chk("bp_level", 64'(level), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        sel = 4'd13; dst = 5'd4; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_err_cnt", 64'(err_cnt), 64'd0);
        chk("bp_level_hold", 64'(level), 64'd2);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back transfers with wb_ready toggling every cycle.
        wb_ready = 1'b0;
        tog_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    rand_data();
                    send(4'($urandom_range(0, 8)), 5'($urandom_range(1, 31)));
                end
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1;
                    wb_ready = ~wb_ready;
                end
            end
        join
        wb_ready = 1'b1;
        drain();

        // Random mix including illegal selects and r0 targets.
        tog_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    rand_data();
                    send(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1;
                    wb_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        wb_ready = 1'b1;
        drain();

        // Illegal select and saturation.
        sync_reset();
        wb_ready = 1'b1;
        rand_data();
        send(4'd12, 5'd7);
        @(negedge clk);
        chk("ill_wb_data", 64'(wb_data), 64'd0);
        chk("ill_wb_we", 64'(wb_we), 64'd0);
        chk("ill_wb_addr", 64'(wb_addr), 64'd7);
        chk("ill_err_sel", 64'(err_sel), 64'd1);
        chk("ill_err_cnt", 64'(err_cnt), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(9, 15)), 5'($urandom_range(0, 31)));
        end
        drain();
        chk("ill_sat", 64'(err_cnt), 64'd255);

        // r0 guard.
        alu_out = 32'd5;
        send(4'd0, 5'd0);
        @(negedge clk);
        chk("r0_data", 64'(wb_data), 64'd5);
        chk("r0_addr", 64'(wb_addr), 64'd0);
        chk("r0_we", 64'(wb_we), 64'd0);
        chk("r0_err_cnt", 64'(err_cnt), 64'd255);
        @(posedge clk);
        #1;
        drain();

        // Asynchronous reset pulse with the buffer full.
        wb_ready = 1'b0;
        rand_data();
        send(4'd1, 5'd5);
        send(4'd2, 5'd6);
        @(negedge clk);
        chk("mid_level_full", 64'(level), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        chk("mid_wb_valid", 64'(wb_valid), 64'd0);
        chk("mid_level", 64'(level), 64'd0);
        chk("mid_err_sel", 64'(err_sel), 64'd0);
        chk("mid_err_cnt", 64'(err_cnt), 64'd0);
        chk("mid_wb_data", 64'(wb_data), 64'd0);
        #4;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        send(4'd6, 5'd9);
        @(negedge clk);
        chk("mid_head_valid", 64'(wb_valid), 64'd1);
        chk("mid_head_data", 64'(wb_data), 64'd1);
        chk("mid_head_addr", 64'(wb_addr), 64'd9);
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
